// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue stage: operation codes, RV32I major opcodes and
// immediate selection.
package alu_pkg;

  localparam int unsigned DataWidthDefault    = 32;
  localparam int unsigned OpcodeLengthDefault = 4;

  typedef enum logic [3:0] {
    AluAnd = 4'b0000,
    AluOr  = 4'b0001,
    AluXor = 4'b1001,
    AluAdd = 4'b0010,
    AluSub = 4'b0110,
    AluEq  = 4'b1000,
    AluNe  = 4'b1110,
    AluGe  = 4'b1010,
    AluLt  = 4'b1100,
    AluSll = 4'b0100,
    AluSrl = 4'b0101,
    AluSra = 4'b0111
  } alu_op_e;

  localparam logic [6:0] OpcR      = 7'b0110011;
  localparam logic [6:0] OpcI      = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;

  localparam logic [6:0] Funct7Base = 7'b0000000;
  localparam logic [6:0] Funct7Alt  = 7'b0100000;

  // ImmNone selects rs2_data as the second operand.
  typedef enum logic [1:0] {
    ImmNone,
    ImmI,
    ImmS,
    ImmShamt
  } imm_sel_e;

endpackage

// File: rtl/alu_issue_if.sv
// Issue-stage bundle: instruction/operand input handshake, flush, and registered ALU command.
interface alu_issue_if
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DataWidthDefault,
  parameter int unsigned OPCODE_LENGTH = OpcodeLengthDefault
);
  logic                     in_valid;
  logic                     in_ready;
  logic [31:0]              instr;
  logic [DATA_WIDTH-1:0]    rs1_data;
  logic [DATA_WIDTH-1:0]    rs2_data;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [OPCODE_LENGTH-1:0] out_operation;
  logic [DATA_WIDTH-1:0]    out_srca;
  logic [DATA_WIDTH-1:0]    out_srcb;
  logic [4:0]               out_rd;
  logic                     out_regwrite;
  logic                     out_branch;
  logic                     out_illegal;

  modport master (
    output in_valid, instr, rs1_data, rs2_data, flush, out_ready,
    input  in_ready, out_valid, out_operation, out_srca, out_srcb, out_rd,
           out_regwrite, out_branch, out_illegal
  );

  modport slave (
    input  in_valid, instr, rs1_data, rs2_data, flush, out_ready,
    output in_ready, out_valid, out_operation, out_srca, out_srcb, out_rd,
           out_regwrite, out_branch, out_illegal
  );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational RV32I decoder: instruction word to ALU operation, immediate select and flags.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output alu_op_e     operation,
  output imm_sel_e    imm_sel,
  output logic        regwrite,
  output logic        branch,
  output logic        illegal
);
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal;
  logic       unused_fields;

  assign opcode        = instr[6:0];
  assign funct3        = instr[14:12];
  assign funct7        = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    operation = AluAdd;
    imm_sel   = ImmNone;
    regwrite  = 1'b0;
    branch    = 1'b0;
    legal     = 1'b1;
    case (opcode)
      OpcR: begin
        regwrite = 1'b1;
        if (funct7 == Funct7Base) begin
          case (funct3)
            3'b000:  operation = AluAdd;
            3'b001:  operation = AluSll;
            3'b010:  operation = AluLt;
            3'b100:  operation = AluXor;
            3'b101:  operation = AluSrl;
            3'b110:  operation = AluOr;
            3'b111:  operation = AluAnd;
            default: legal = 1'b0;
          endcase
        end else if (funct7 == Funct7Alt) begin
          case (funct3)
            3'b000:  operation = AluSub;
            3'b101:  operation = AluSra;
            default: legal = 1'b0;
          endcase
        end else begin
          legal = 1'b0;
        end
      end
      OpcI: begin
        regwrite = 1'b1;
        imm_sel  = ImmI;
        case (funct3)
          3'b000: operation = AluAdd;
          3'b010: operation = AluLt;
          3'b100: operation = AluXor;
          3'b110: operation = AluOr;
          3'b111: operation = AluAnd;
          3'b001: begin
            imm_sel   = ImmShamt;
            operation = AluSll;
            legal     = (funct7 == Funct7Base);
          end
          3'b101: begin
            imm_sel   = ImmShamt;
            operation = (funct7 == Funct7Alt) ? AluSra : AluSrl;
            legal     = (funct7 == Funct7Base) || (funct7 == Funct7Alt);
          end
          default: legal = 1'b0;
        endcase
      end
      OpcLoad: begin
        imm_sel  = ImmI;
        regwrite = 1'b1;
      end
      OpcStore: imm_sel = ImmS;
      OpcBranch: begin
        branch = 1'b1;
        case (funct3)
          3'b000:  operation = AluEq;
          3'b001:  operation = AluNe;
          3'b100:  operation = AluLt;
          3'b101:  operation = AluGe;
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
    // Anything unrecognised degrades to a harmless ADD with no side effects.
    if (!legal) begin
      operation = AluAdd;
      regwrite  = 1'b0;
      branch    = 1'b0;
    end
    illegal = !legal;
  end
endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes an RV32I instruction and registers the ALU command behind a
// single-entry valid/ready pipeline register with flush.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DataWidthDefault,
  parameter int unsigned OPCODE_LENGTH = OpcodeLengthDefault
) (
  input logic        clk,
  input logic        reset,
  alu_issue_if.slave bus
);
  alu_op_e  dec_op;
  imm_sel_e dec_imm_sel;
  logic     dec_regwrite;
  logic     dec_branch;
  logic     dec_illegal;

  alu_op_decode u_decode (
    .instr     (bus.instr),
    .operation (dec_op),
    .imm_sel   (dec_imm_sel),
    .regwrite  (dec_regwrite),
    .branch    (dec_branch),
    .illegal   (dec_illegal)
  );

  logic                     valid_q, valid_d;
  logic [OPCODE_LENGTH-1:0] op_q;
  logic [DATA_WIDTH-1:0]    srca_q, srcb_q, srcb_d;
  logic [4:0]               rd_q;
  logic                     regwrite_q, branch_q, illegal_q;
  logic                     ready;
  logic                     transfer;

  // flush is folded into ready so a flushed cycle can never accept input.
  assign ready    = (!valid_q || bus.out_ready) && !bus.flush;
  assign transfer = bus.in_valid && ready;

  always_comb begin
    unique case (dec_imm_sel)
      ImmI:     srcb_d = {{(DATA_WIDTH-12){bus.instr[31]}}, bus.instr[31:20]};
      ImmS:     srcb_d = {{(DATA_WIDTH-12){bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
      ImmShamt: srcb_d = {{(DATA_WIDTH-5){1'b0}}, bus.instr[24:20]};
      ImmNone:  srcb_d = bus.rs2_data;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    if (bus.flush)         valid_d = 1'b0;
    else if (transfer)     valid_d = 1'b1;
    else if (bus.out_ready) valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      op_q       <= '0;
      srca_q     <= '0;
      srcb_q     <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      branch_q   <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (transfer) begin
        op_q       <= OPCODE_LENGTH'(dec_op);
        srca_q     <= bus.rs1_data;
        srcb_q     <= srcb_d;
        rd_q       <= bus.instr[11:7];
        regwrite_q <= dec_regwrite;
        branch_q   <= dec_branch;
        illegal_q  <= dec_illegal;
      end
    end
  end

  assign bus.in_ready      = ready;
  assign bus.out_valid     = valid_q;
  assign bus.out_operation = op_q;
  assign bus.out_srca      = srca_q;
  assign bus.out_srcb      = srcb_q;
  assign bus.out_rd        = rd_q;
  assign bus.out_regwrite  = regwrite_q;
  assign bus.out_branch    = branch_q;
  assign bus.out_illegal   = illegal_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed RV32I cases plus randomized handshake
// traffic against a mnemonic-table reference model.
module tb_alu_issue_stage;
  import alu_pkg::*;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  alu_issue_if #(.DATA_WIDTH(W), .OPCODE_LENGTH(4)) bus ();

  alu_issue_stage #(.DATA_WIDTH(W), .OPCODE_LENGTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic [4:0]  rd;
    logic        rw;
    logic        br;
    logic        ill;
  } cmd_t;

  cmd_t m_cmd;
  logic m_valid;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] op_of(input string mn);
    case (mn)
      "and":   return 4'b0000;
      "or":    return 4'b0001;
      "xor":   return 4'b1001;
      "sub":   return 4'b0110;
      "slt":   return 4'b1100;
      "blt":   return 4'b1100;
      "sll":   return 4'b0100;
      "srl":   return 4'b0101;
      "sra":   return 4'b0111;
      "beq":   return 4'b1000;
      "bne":   return 4'b1110;
      "bge":   return 4'b1010;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic cmd_t ref_cmd(input logic [31:0] ins, input logic [31:0] a,
                                   input logic [31:0] b);
    cmd_t  c;
    string mn;
    string base [8];
    string brn [8];
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic signed [31:0] imm_i, imm_s;
    base  = '{"add", "sll", "slt", "", "xor", "srl", "or", "and"};
    brn   = '{"beq", "bne", "", "", "blt", "bge", "", ""};
    opc   = ins[6:0];
    f3    = ins[14:12];
    f7    = ins[31:25];
    imm_i = $signed(ins[31:20]);
    imm_s = $signed({ins[31:25], ins[11:7]});
    c.srca = a;
    c.rd   = ins[11:7];
    c.srcb = b;
    c.rw   = 1'b0;
    c.br   = 1'b0;
    mn     = "";
    case (opc)
      7'h33: begin
        c.rw = 1'b1;
        if (f7 == 7'h00) mn = base[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) mn = "sub";
        else if (f7 == 7'h20 && f3 == 3'd5) mn = "sra";
      end
      7'h13: begin
        c.rw = 1'b1;
        if (f3 == 3'd1) mn = (f7 == 7'h00) ? "sll" : "";
        else if (f3 == 3'd5) mn = (f7 == 7'h00) ? "srl" : (f7 == 7'h20) ? "sra" : "";
        else mn = base[f3];
        c.srcb = (f3 == 3'd1 || f3 == 3'd5) ? 32'(ins[24:20]) : imm_i;
      end
      7'h03: begin mn = "load";  c.rw = 1'b1; c.srcb = imm_i; end
      7'h23: begin mn = "store"; c.srcb = imm_s; end
      7'h63: begin mn = brn[f3]; c.br = 1'b1; end
      default: mn = "";
    endcase
    c.ill = (mn == "");
    if (c.ill) begin
      c.rw = 1'b0;
      c.br = 1'b0;
    end
    c.op = op_of(mn);
    return c;
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b, input logic ordy, input logic fl);
    bus.in_valid  = v;
    bus.instr     = ins;
    bus.rs1_data  = a;
    bus.rs2_data  = b;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  task automatic compare_outputs();
    check_eq("out_valid", bus.out_valid, m_valid);
    if (m_valid) begin
      check_eq("operation", bus.out_operation, m_cmd.op);
      check_eq("srca", bus.out_srca, m_cmd.srca);
      check_eq("rd", bus.out_rd, m_cmd.rd);
      check_eq("regwrite", bus.out_regwrite, m_cmd.rw);
      check_eq("branch", bus.out_branch, m_cmd.br);
      check_eq("illegal", bus.out_illegal, m_cmd.ill);
      if (!m_cmd.ill) check_eq("srcb", bus.out_srcb, m_cmd.srcb);
    end
  endtask

  task automatic check_reset_state();
    check_eq("rst_valid", bus.out_valid, 0);
    check_eq("rst_regwrite", bus.out_regwrite, 0);
    check_eq("rst_branch", bus.out_branch, 0);
    check_eq("rst_illegal", bus.out_illegal, 0);
    check_eq("rst_operation", bus.out_operation, 0);
    check_eq("rst_srca", bus.out_srca, 0);
    check_eq("rst_srcb", bus.out_srcb, 0);
    check_eq("rst_rd", bus.out_rd, 0);
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle();
    logic exp_ready;
    logic nv;
    cmd_t nc;
    #1;
    exp_ready = (!m_valid || bus.out_ready) && !bus.flush;
    check_eq("in_ready", bus.in_ready, exp_ready);
    nv = m_valid;
    nc = m_cmd;
    if (bus.flush) nv = 1'b0;
    else if (bus.in_valid && exp_ready) begin
      nv = 1'b1;
      nc = ref_cmd(bus.instr, bus.rs1_data, bus.rs2_data);
    end else if (bus.out_ready) nv = 1'b0;
    @(posedge clk);
    #1;
    m_valid = nv;
    m_cmd   = nc;
    compare_outputs();
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0]  f7;
    ins = $urandom;
    case ($urandom_range(0, 2))
      0:       f7 = 7'h00;
      1:       f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    case ($urandom_range(0, 5))
      0: ins = {f7, ins[24:7], 7'b0110011};
      1: ins = {f7, ins[24:7], 7'b0010011};
      2: ins = {ins[31:7], 7'b0000011};
      3: ins = {ins[31:7], 7'b0100011};
      4: ins = {ins[31:7], 7'b1100011};
      default: ;
    endcase
    return ins;
  endfunction

  initial begin
    m_valid = 1'b0;
    m_cmd   = '{op: 4'd0, srca: 32'd0, srcb: 32'd0, rd: 5'd0, rw: 1'b0, br: 1'b0, ill: 1'b0};
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_state();
    reset = 1'b0;

    // sub x3,x1,x2 accepted on the first edge after reset release
    drive(1'b1, 32'h402081B3, 32'd10, 32'd3, 1'b1, 1'b0);
    cycle();
    check_eq("sub_valid", bus.out_valid, 1);
    check_eq("sub_op", bus.out_operation, 4'b0110);
    check_eq("sub_srca", bus.out_srca, 10);
    check_eq("sub_srcb", bus.out_srcb, 3);
    check_eq("sub_rd", bus.out_rd, 3);
    check_eq("sub_rw", bus.out_regwrite, 1);

    drive(1'b1, 32'h40435293, 32'h8000_0000, 32'hDEAD_BEEF, 1'b1, 1'b0);
    cycle();
    check_eq("srai_op", bus.out_operation, 4'b0111);
    check_eq("srai_srcb", bus.out_srcb, 4);
    check_eq("srai_rw", bus.out_regwrite, 1);

    drive(1'b1, 32'hFFF00093, 32'd5, 32'd0, 1'b1, 1'b0);
    cycle();
    check_eq("addi_op", bus.out_operation, 4'b0010);
    check_eq("addi_srcb", bus.out_srcb, 32'hFFFF_FFFF);

    drive(1'b1, 32'h0020D063, 32'd7, 32'd7, 1'b1, 1'b0);
    cycle();
    check_eq("bge_op", bus.out_operation, 4'b1010);
    check_eq("bge_branch", bus.out_branch, 1);
    check_eq("bge_rw", bus.out_regwrite, 0);

    // Three stalled cycles with fresh input offered, then release with no bubble
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, rand_instr(), $urandom, $urandom, 1'b0, 1'b0);
      cycle();
      check_eq("stall_hold_op", bus.out_operation, 4'b1010);
    end
    drive(1'b1, 32'h0020C233, 32'd1, 32'd2, 1'b1, 1'b0);
    cycle();
    check_eq("release_valid", bus.out_valid, 1);
    check_eq("release_op", bus.out_operation, 4'b1001);

    drive(1'b1, 32'h402081B3, 32'd1, 32'd2, 1'b0, 1'b1);
    cycle();
    check_eq("flush_valid", bus.out_valid, 0);
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    cycle();
    check_eq("flush_dropped", bus.out_valid, 0);

    drive(1'b1, 32'h0000007F, 32'd1, 32'd2, 1'b1, 1'b0);
    cycle();
    check_eq("ill_illegal", bus.out_illegal, 1);
    check_eq("ill_rw", bus.out_regwrite, 0);
    check_eq("ill_op", bus.out_operation, 4'b0010);

    // Reset during a stall must drop the held command without waiting for a clock
    drive(1'b1, 32'h402081B3, 32'd9, 32'd4, 1'b1, 1'b0);
    cycle();
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_reset_state();
    m_valid = 1'b0;
    m_cmd   = '{op: 4'd0, srca: 32'd0, srcb: 32'd0, rd: 5'd0, rw: 1'b0, br: 1'b0, ill: 1'b0};
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 500; i++) begin
      drive(($urandom_range(0, 9) < 7), rand_instr(), $urandom, $urandom,
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
